noc_packet_arbiter: RTL and testbench
=====================================

# noc_packet_arbiter

Packet-level scheduler that shares one `noc_flit_if` output among `REQUESTS` flit streams, typically the per-class FIFO outputs of a router input port or the input ports feeding one router output. It grants one stream per packet (header through tail, wormhole lock) with round-robin fairness. It monitors packet length with a flit counter and flags protocol violations. It replaces the separate arbiter plus mux pair with one sequenced controller that exposes grant and error status.

## Interface
- `CONFIG`, `NOC_DEFAULT_CONFIG`, NoC configuration (flit/header widths).
- `REQUESTS`, 2, number of input streams (2..8).
- `MAX_FLITS`, 64, maximum legal flits per packet, header and tail included.
- `clk` input 1: single clock.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising `clk` edge.
- `flit_in_if[REQUESTS]` `noc_flit_if.slave`: input streams.
- `flit_out_if` `noc_flit_if.master`: shared output.
- `o_grant` output REQUESTS: one-hot current owner; all zero when idle.
- `o_busy` output 1: a packet is in transfer.
- `o_length_error` output 1: sticky; set when a packet exceeds `MAX_FLITS`.
- `o_framing_error` output 1: sticky; set when a non-header flit is valid at an input while no packet is in transfer.
- `i_clear_error` input 1: clears both sticky errors.

## Operation
- State machine has three states: IDLE, GRANT, XFER.
- **IDLE:**
  - `request[i] = flit_in_if[i].valid && is_header_flit(flit_in_if[i].flit)`.
  - If any request is set, the winner is the first set bit searching upward from `last+1`, wrapping modulo REQUESTS. The winner is registered into `o_grant` and the FSM moves to GRANT.
  - All input `ready` signals are 0.
- **GRANT:** one cycle only.
  - Flit counter is loaded with 0. `o_busy` becomes 1 and the FSM moves to XFER.
  - Gives the output mux a registered select.
- **XFER:**
  - `flit_out_if.valid` and `flit` come from the granted input. `flit_out_if.ready` goes back to the granted input only; all other inputs see `ready = 0`.
  - Each output handshake increments the counter, which saturates at `MAX_FLITS`.
  - On a tail handshake:
    - `last` takes the granted index.
    - `o_grant` and `o_busy` clear and the FSM returns to IDLE.
  - A handshake of a non-tail flit while the counter equals `MAX_FLITS-1` sets `o_length_error`. Transfer continues until the tail arrives; the block never truncates a packet.
- **Framing check:** in IDLE, a valid non-header flit at any input sets `o_framing_error`. That input is never granted until a header appears.
- **Simultaneous error set and clear:** set wins over `i_clear_error` in the same cycle.
- **Reset:**
  - State goes to IDLE and `last` to REQUESTS-1, so input 0 has first priority.
  - Counter, `o_grant`, `o_busy` and both error flags go to 0.
  - Reset mid-packet abandons the transfer. Downstream recovery is the system's responsibility.

## Timing
- Arbitration latency: header valid in IDLE at cycle T gives `o_grant` at T+1 and the first output handshake at T+2 at the earliest.
- Per-packet overhead is two bubble cycles: the IDLE evaluation and the GRANT cycle.
- XFER is combinational pass-through: one flit per cycle when source and sink are both ready.
- Tail handshake at cycle T gives IDLE at T+1, so the next grant appears at T+2.
- Counter width: `$clog2(MAX_FLITS+1)`.
- Request changes during GRANT and XFER are ignored; grant is locked.

## Configuration
- Macro `NOC_PACKET_ARBITER_RESPONSE_PRIORITY_EN`.
- **Defined:**
  - In IDLE, requests whose header satisfies `is_response_header` form a high-priority class and win over request-class headers.
  - Round-robin applies within each class and shares the single `last` pointer.
- **Undefined:** pure round-robin over all requests, regardless of header class.

## Structure
- `noc_config`, `NOC_DEFAULT_CONFIG` and a new `noc_packet_arbiter_state` enum (IDLE, GRANT, XFER) belong in `noc_config_pkg`.
- Header and flit predicates come from the existing flit and packet utility includes.
- One sub-module, `noc_rr_select`: a combinational rotate-and-priority-encode taking request, `last` and REQUESTS, returning a one-hot winner. It is instantiated twice when the macro is defined, once per class.

## Test plan
- Headers on inputs 0 and 1 in the same cycle after reset:
  - Input 0 granted at T+1.
  - Its 3-flit packet is forwarded at T+2..T+4, then input 1 is granted at T+6.
- Continuous single-flit packets on all 4 inputs (REQUESTS=4): grant order is 0,1,2,3,0 with exactly 2 idle cycles between tail and next header out.
- Sink ready toggling 1010… during a 5-flit packet:
  - Exactly 5 output handshakes occur in order.
  - The non-granted input with a pending header sees `ready = 0` throughout.
- 66-flit packet with MAX_FLITS=64:
  - `o_length_error` rises on the 64th non-tail handshake.
  - All 66 flits are delivered; `i_clear_error` then clears the flag.
- Body flit valid on input 1 while idle: `o_framing_error` is set and input 1 is never granted.
- With the macro defined, a request-class header on input 0 and a response-class header on input 1 arrive together: input 1 is granted first.

Source files
------------

// File: rtl/noc_config_pkg.sv
// Shared NoC configuration, flit-control predicates and the packet arbiter state type.
// Flit control field occupies flit[2:0]: bit0 header, bit1 tail, bit2 response class.
package noc_config_pkg;

  typedef struct packed {
    int unsigned flit_w;
    int unsigned hdr_w;
  } noc_config;

  localparam noc_config NOC_DEFAULT_CONFIG = '{flit_w: 32, hdr_w: 3};

  localparam int unsigned FLIT_CTL_W = 3;

  typedef enum logic [1:0] {
    NPA_IDLE  = 2'd0,
    NPA_GRANT = 2'd1,
    NPA_XFER  = 2'd2
  } noc_packet_arbiter_state;

  // True for the first flit of a packet (single-flit packets are header and tail).
  function automatic logic is_header_flit(input logic [FLIT_CTL_W-1:0] ctl);
    return ctl[0];
  endfunction

  // True for the last flit of a packet.
  function automatic logic is_tail_flit(input logic [FLIT_CTL_W-1:0] ctl);
    return ctl[1];
  endfunction

  // True for a header flit that belongs to the response class.
  function automatic logic is_response_header(input logic [FLIT_CTL_W-1:0] ctl);
    return ctl[0] & ctl[2];
  endfunction

endpackage

// File: rtl/noc_flit_if.sv
// Valid/ready flit channel between NoC stages.
interface noc_flit_if #(
  parameter int unsigned FLIT_W = 32
);
  logic              valid;
  logic              ready;
  logic [FLIT_W-1:0] flit;

  modport master (output valid, output flit, input ready);
  modport slave  (input valid, input flit, output ready);
endinterface

// File: rtl/noc_rr_select.sv
// Round-robin pick: first set request searching upward from last+1, wrapping.
module noc_rr_select
  import noc_config_pkg::*;
#(
  parameter int unsigned REQUESTS = 2
) (
  input  logic [REQUESTS-1:0]         req,
  input  logic [$clog2(REQUESTS)-1:0] last,
  output logic [REQUESTS-1:0]         grant_c
);

  localparam int unsigned IDX_W = $clog2(REQUESTS);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Rotate-and-priority-encode as an ordered scan starting after last.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= REQUESTS; k++) begin
      idx = IDX_W'((32'(last) + k) % REQUESTS);
      if (!found && req[idx]) begin
        grant_c[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one flit output among REQUESTS streams.
// Optional macro NOC_PACKET_ARBITER_RESPONSE_PRIORITY_EN gives response headers priority.
module noc_packet_arbiter
  import noc_config_pkg::*;
#(
  parameter noc_config   CONFIG    = NOC_DEFAULT_CONFIG,
  parameter int unsigned REQUESTS  = 2,
  parameter int unsigned MAX_FLITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  noc_flit_if.slave           flit_in_if [REQUESTS],
  noc_flit_if.master          flit_out_if,
  output logic [REQUESTS-1:0] o_grant,
  output logic                o_busy,
  output logic                o_length_error,
  output logic                o_framing_error,
  input  logic                i_clear_error
);

  localparam int unsigned FLIT_W = CONFIG.flit_w;
  localparam int unsigned IDX_W  = $clog2(REQUESTS);
  localparam int unsigned CNT_W  = $clog2(MAX_FLITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'(NPA_IDLE);
  localparam logic [1:0] ST_GRANT = 2'(NPA_GRANT);
  localparam logic [1:0] ST_XFER  = 2'(NPA_XFER);

  logic [1:0]          state_q, state_d;
  logic [REQUESTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                len_err_q, len_err_d;
  logic                frm_err_q, frm_err_d;

  logic [REQUESTS-1:0] in_valid;
  logic [FLIT_W-1:0]   in_flit [REQUESTS];
  logic [REQUESTS-1:0] in_ready_c;
  logic [REQUESTS-1:0] hdr_c;
  logic [REQUESTS-1:0] req_c;
  logic [REQUESTS-1:0] win_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic                framing_c;
  logic                xfer_c;
  logic                hs_c;
  logic                tail_c;

  // Flatten the input interface array into local vectors.
  for (genvar g = 0; g < REQUESTS; g++) begin : g_in
    assign in_valid[g]         = flit_in_if[g].valid;
    assign in_flit[g]          = flit_in_if[g].flit;
    assign flit_in_if[g].ready = in_ready_c[g];
    assign hdr_c[g]            = is_header_flit(flit_in_if[g].flit[FLIT_CTL_W-1:0]);
  end

  assign req_c     = in_valid & hdr_c;
  assign framing_c = |(in_valid & ~hdr_c);

`ifdef NOC_PACKET_ARBITER_RESPONSE_PRIORITY_EN
  logic [REQUESTS-1:0] rsp_c;
  logic [REQUESTS-1:0] rsp_win_c;
  logic [REQUESTS-1:0] oth_win_c;

  for (genvar g = 0; g < REQUESTS; g++) begin : g_rsp
    assign rsp_c[g] = is_response_header(flit_in_if[g].flit[FLIT_CTL_W-1:0]);
  end

  noc_rr_select #(.REQUESTS(REQUESTS)) u_rr_rsp (
    .req     (req_c & rsp_c),
    .last    (last_q),
    .grant_c (rsp_win_c)
  );

  noc_rr_select #(.REQUESTS(REQUESTS)) u_rr_req (
    .req     (req_c & ~rsp_c),
    .last    (last_q),
    .grant_c (oth_win_c)
  );

  assign win_c = (|rsp_win_c) ? rsp_win_c : oth_win_c;
`else
  noc_rr_select #(.REQUESTS(REQUESTS)) u_rr (
    .req     (req_c),
    .last    (last_q),
    .grant_c (win_c)
  );
`endif

  // One-hot winner to index.
  always_comb begin
    win_idx_c = '0;
    for (int unsigned i = 0; i < REQUESTS; i++) begin
      if (win_c[i]) win_idx_c = IDX_W'(i);
    end
  end

  // Wormhole pass-through from the locked input during XFER.
  assign xfer_c            = (state_q == ST_XFER);
  assign flit_out_if.valid = xfer_c && in_valid[sel_q];
  assign flit_out_if.flit  = in_flit[sel_q];
  assign in_ready_c        = xfer_c ? (grant_q & {REQUESTS{flit_out_if.ready}}) : '0;
  assign hs_c              = flit_out_if.valid && flit_out_if.ready;
  assign tail_c            = is_tail_flit(in_flit[sel_q][FLIT_CTL_W-1:0]);

  // Next-state, grant lock, flit counter and sticky error flags (set beats clear).
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    len_err_d = len_err_q & ~i_clear_error;
    frm_err_d = frm_err_q & ~i_clear_error;
    case (state_q)
      ST_IDLE: begin
        if (framing_c) frm_err_d = 1'b1;
        if (|req_c) begin
          grant_d = win_c;
          sel_d   = win_idx_c;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (hs_c) begin
          if (cnt_q != CNT_W'(MAX_FLITS)) cnt_d = cnt_q + CNT_W'(1);
          if (!tail_c && (cnt_q == CNT_W'(MAX_FLITS - 1))) len_err_d = 1'b1;
          if (tail_c) begin
            last_d  = sel_q;
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= IDX_W'(REQUESTS - 1);
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign o_grant         = grant_q;
  assign o_busy          = busy_q;
  assign o_length_error  = len_err_q;
  assign o_framing_error = frm_err_q;

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Self-checking bench for noc_packet_arbiter (REQUESTS=4, MAX_FLITS=64).
// Flit layout: [31:28] source, [27:16] packet seq, [15:3] flit index, [2:0] control.
module tb_noc_packet_arbiter;
  import noc_config_pkg::*;

  localparam int R    = 4;
  localparam int MAXF = 64;
  localparam int FW   = 32;

  typedef logic [FW-1:0] flit_q_t [$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          sink_ready = 1'b0;
  logic [R-1:0]  src_valid = '0;
  logic [FW-1:0] src_flit [R];
  logic [R-1:0]  dut_ready;
  logic          out_valid;
  logic [FW-1:0] out_flit;
  logic [R-1:0]  o_grant;
  logic          o_busy, o_length_error, o_framing_error;

  noc_flit_if #(.FLIT_W(FW)) in_if [R] ();
  noc_flit_if #(.FLIT_W(FW)) out_if ();

  for (genvar g = 0; g < R; g++) begin : g_src
    assign in_if[g].valid = src_valid[g];
    assign in_if[g].flit  = src_flit[g];
    assign dut_ready[g]   = in_if[g].ready;
  end
  assign out_if.ready = sink_ready;
  assign out_valid    = out_if.valid;
  assign out_flit     = out_if.flit;

  noc_packet_arbiter #(
    .CONFIG(NOC_DEFAULT_CONFIG), .REQUESTS(R), .MAX_FLITS(MAXF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flit_in_if      (in_if),
    .flit_out_if     (out_if),
    .o_grant         (o_grant),
    .o_busy          (o_busy),
    .o_length_error  (o_length_error),
    .o_framing_error (o_framing_error),
    .i_clear_error   (clear)
  );

  always #5 clk = ~clk;

  // Bench state
  flit_q_t q [R];
  int  checks = 0, errors = 0;
  int  cyc = 0, pkt_seq = 0, flits_added = 0, hs_total = 0;
  int  valid_pct = 100, sink_mode = 0;
  bit  rst_req = 1'b1, clr_req = 1'b0;
  int  hs_by_src [R];
  int  obs_g [$];
  int  obs_c [$];
  logic [R-1:0] prev_grant = '0;

  // Reference model: owner of the output, grant-cycle flag, fairness pointer, counters
  int  m_owner = -1, m_last = R - 1, m_cnt = 0;
  bit  m_pending = 0, m_len = 0, m_frm = 0, m_init = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < R; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int src, input int len, input bit resp);
    for (int k = 0; k < len; k++) begin
      logic [2:0] ctl;
      ctl = {(k == 0) && resp, k == len - 1, k == 0};
      q[src].push_back({4'(src), 12'(pkt_seq), 13'(k), ctl});
    end
    pkt_seq++;
    flits_added += len;
  endtask

  task automatic clear_logs();
    obs_g.delete();
    obs_c.delete();
    for (int i = 0; i < R; i++) hs_by_src[i] = 0;
  endtask

  // Winner among header requests: response class first when enabled, round robin after m_last.
  function automatic int pick();
    int best = -1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 1; k <= R; k++) begin
        int j;
        bit want;
        j = (m_last + k) % R;
`ifdef NOC_PACKET_ARBITER_RESPONSE_PRIORITY_EN
        want = (pass == 0) ? src_flit[j][2] : !src_flit[j][2];
`else
        want = (pass == 0);
`endif
        if (best < 0 && want && src_valid[j] && src_flit[j][0]) best = j;
      end
    end
    return best;
  endfunction

  task automatic drive();
    rst_n = !rst_req;
    clear = clr_req;
    for (int i = 0; i < R; i++) begin
      src_flit[i]  = (q[i].size() > 0) ? q[i][0] : '0;
      src_valid[i] = (q[i].size() > 0) && ($urandom_range(99, 0) < valid_pct);
    end
    case (sink_mode)
      0:       sink_ready = 1'b1;
      1:       sink_ready = (cyc % 2) == 0;
      default: sink_ready = 1'($urandom_range(1, 0));
    endcase
  endtask

  task automatic check_outputs();
    logic [R-1:0] exp_grant, exp_ready;
    bit xfer, exp_ov;
    xfer      = (m_owner >= 0) && !m_pending;
    exp_grant = (m_owner >= 0) ? (R'(1) << m_owner) : '0;
    exp_ready = (xfer && sink_ready) ? (R'(1) << m_owner) : '0;
    exp_ov    = xfer ? src_valid[m_owner] : 1'b0;
    chk("grant", o_grant, exp_grant);
    chk("busy", o_busy, xfer);
    chk("length_error", o_length_error, m_len);
    chk("framing_error", o_framing_error, m_frm);
    chk("in_ready", dut_ready, exp_ready);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) chk("out_flit", out_flit, q[m_owner][0]);
    if (o_grant !== prev_grant && o_grant != '0) begin
      obs_g.push_back(int'(o_grant));
      obs_c.push_back(cyc);
    end
    prev_grant = o_grant;
    if (out_valid === 1'b1 && sink_ready) begin
      hs_total++;
      if (int'(out_flit[31:28]) < R) hs_by_src[int'(out_flit[31:28])]++;
    end
  endtask

  task automatic model_step();
    bit nl, nf, tail;
    for (int i = 0; i < R; i++)
      if (src_valid[i] && dut_ready[i] === 1'b1 && q[i].size() > 0) void'(q[i].pop_front());
    if (!rst_n) begin
      m_owner = -1; m_pending = 0; m_last = R - 1; m_cnt = 0;
      m_len = 0; m_frm = 0; m_init = 1;
      return;
    end
    if (!m_init) return;
    nl = m_len && !clear;
    nf = m_frm && !clear;
    if (m_owner < 0) begin
      for (int i = 0; i < R; i++) if (src_valid[i] && !src_flit[i][0]) nf = 1;
      m_owner   = pick();
      m_pending = (m_owner >= 0);
    end else if (m_pending) begin
      m_pending = 0;
      m_cnt     = 0;
    end else if (src_valid[m_owner] && sink_ready) begin
      tail = src_flit[m_owner][1];
      if (!tail && m_cnt == MAXF - 1) nl = 1;
      if (m_cnt < MAXF) m_cnt++;
      if (tail) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    m_len = nl;
    m_frm = nf;
  endtask

  task automatic tick();
    @(negedge clk);
    drive();
    #1;
    if (m_init) check_outputs();
    model_step();
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    for (int i = 0; i < R; i++) q[i].delete();
    repeat (n) tick();
    rst_req = 1'b0;
  endtask

  task automatic run_drain(input string tag, input int max);
    int n = 0;
    while (n < max && !(all_empty() && m_owner < 0)) begin
      tick();
      n++;
    end
    chk(tag, all_empty() && m_owner < 0, 1);
    repeat (2) tick();
  endtask

  initial begin
    int base_hs, base_added;
    for (int i = 0; i < R; i++) src_flit[i] = '0;
    clear_logs();

    // Reset values
    do_reset(3);
    tick();
    chk("reset_grant", o_grant, '0);
    chk("reset_busy", o_busy, 0);

    // Simultaneous headers on inputs 0 and 1, 3-flit packets
    clear_logs();
    add_pkt(0, 3, 0);
    add_pkt(1, 3, 0);
    run_drain("s1_drain", 100);
    chk("s1_ngrants", obs_g.size(), 2);
    if (obs_g.size() >= 2) begin
      chk("s1_first", obs_g[0], 1);
      chk("s1_second", obs_g[1], 2);
      chk("s1_gap", obs_c[1] - obs_c[0], 5);
    end
    chk("s1_hs0", hs_by_src[0], 3);

    // Continuous single-flit packets on all inputs
    do_reset(2);
    clear_logs();
    for (int r = 0; r < 2; r++) for (int i = 0; i < R; i++) add_pkt(i, 1, 0);
    run_drain("s2_drain", 200);
    chk("s2_ngrants", obs_g.size(), 8);
    if (obs_g.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("s2_order", obs_g[k], 1 << (k % R));
      for (int k = 1; k < 5; k++) chk("s2_gap", obs_c[k] - obs_c[k-1], 3);
    end

    // Sink toggling during a 5-flit packet, pending header on input 2
    do_reset(2);
    clear_logs();
    sink_mode = 1;
    add_pkt(0, 5, 0);
    add_pkt(2, 2, 0);
    run_drain("s3_drain", 200);
    chk("s3_hs0", hs_by_src[0], 5);
    chk("s3_ngrants", obs_g.size(), 2);
    if (obs_g.size() >= 1) chk("s3_first", obs_g[0], 1);
    sink_mode = 0;

    // Length boundary: 64 flits legal, 66 flits flagged, then cleared
    do_reset(2);
    clear_logs();
    add_pkt(0, 64, 0);
    run_drain("s4a_drain", 300);
    chk("s4_64_noerr", o_length_error, 0);
    clear_logs();
    add_pkt(0, 66, 0);
    run_drain("s4b_drain", 300);
    chk("s4_66_err", o_length_error, 1);
    chk("s4_66_flits", hs_by_src[0], 66);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    chk("s4_cleared", o_length_error, 0);
    // Clear held throughout: set must win on the offending cycle
    add_pkt(1, 66, 0);
    clr_req = 1'b1;
    run_drain("s4c_drain", 300);
    clr_req = 1'b0;

    // Framing: stray body flit on input 1 while idle
    do_reset(2);
    clear_logs();
    q[1].push_back({4'd1, 12'hfff, 13'd0, 3'b000});
    add_pkt(0, 2, 0);
    add_pkt(2, 2, 0);
    repeat (20) tick();
    chk("s5_frm", o_framing_error, 1);
    chk("s5_hs1", hs_by_src[1], 0);
    chk("s5_hs_others", hs_by_src[0] + hs_by_src[2], 4);
    q[1].delete();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    add_pkt(1, 2, 0);
    run_drain("s5_drain", 100);
    chk("s5_frm_clr", o_framing_error, 0);
    chk("s5_hs1_after", hs_by_src[1], 2);

    // Class priority (or pure round robin when disabled)
    do_reset(2);
    clear_logs();
    add_pkt(0, 2, 0);
    add_pkt(1, 2, 1);
    run_drain("s7_drain", 100);
`ifdef NOC_PACKET_ARBITER_RESPONSE_PRIORITY_EN
    if (obs_g.size() >= 1) chk("s7_first", obs_g[0], 2);
`else
    if (obs_g.size() >= 1) chk("s7_first", obs_g[0], 1);
`endif

    // Randomized traffic with random source valid and sink ready
    do_reset(2);
    clear_logs();
    valid_pct  = 70;
    sink_mode  = 2;
    base_hs    = hs_total;
    base_added = flits_added;
    for (int b = 0; b < 5; b++) begin
      for (int p = 0; p < 8; p++)
        add_pkt(int'($urandom_range(R - 1, 0)), int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
      repeat ($urandom_range(30, 0)) tick();
    end
    run_drain("s6_drain", 3000);
    chk("s6_flits", hs_total - base_hs, flits_added - base_added);
    valid_pct = 100;
    sink_mode = 0;

    // Reset in the middle of a packet
    add_pkt(3, 10, 0);
    repeat (6) tick();
    do_reset(2);
    tick();
    chk("midreset_busy", o_busy, 0);
    chk("midreset_grant", o_grant, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
